fetch_seq: RTL and testbench

Instruction fetch and sequencing stage for the PIC10F200-class core. It sits directly upstream of the ALU and drives its 12-bit `ir_bus`. It owns the program counter, the instruction register, the 4-phase (Q1..Q4) instruction-cycle counter and the 2-level hardware call stack. It resolves GOTO/CALL/RETLW, PCL writes and conditional skips by flushing the prefetched word to a NOP.

---
 rtl/pic_pkg.sv | 34 +++
 rtl/call_stack.sv | 48 ++++
 rtl/fetch_seq.sv | 140 ++++++++++++++
 tb/tb_fetch_seq.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared types and constants for the PIC10F200-class fetch/sequencing stage.
package pic_pkg;

  localparam int PC_W = 9;
  localparam int IW   = 12;

  localparam logic [11:0] NOP_INSTR    = 12'h000;

  // Opcode classes, matched as (ir & mask) == match.
  localparam logic [11:0] GOTO_MASK    = 12'hE00;
  localparam logic [11:0] GOTO_MATCH   = 12'hA00;
  localparam logic [11:0] CALL_MASK    = 12'hF00;
  localparam logic [11:0] CALL_MATCH   = 12'h900;
  localparam logic [11:0] RETLW_MASK   = 12'hF00;
  localparam logic [11:0] RETLW_MATCH  = 12'h800;
  localparam logic [11:0] DECFSZ_MASK  = 12'hFC0;
  localparam logic [11:0] DECFSZ_MATCH = 12'h2C0;
  localparam logic [11:0] INCFSZ_MASK  = 12'hFC0;
  localparam logic [11:0] INCFSZ_MATCH = 12'h3C0;

  typedef enum logic [1:0] {
    Q1 = 2'd0,
    Q2 = 2'd1,
    Q3 = 2'd2,
    Q4 = 2'd3
  } q_phase_t;

  function automatic logic op_match(input logic [11:0] ir,
                                    input logic [11:0] mask,
                                    input logic [11:0] match);
    return (ir & mask) == match;
  endfunction

endpackage

// File: rtl/call_stack.sv
// Two-entry hardware return stack. A push onto a full stack drops the
// bottom entry and raises a sticky overflow flag; popping an empty stack
// simply returns whatever stale value is on top.
module call_stack #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         stk_ovf
);

  logic [W-1:0] stk0_r;
  logic [W-1:0] stk1_r;
  logic [1:0]   depth_r;
  logic         ovf_r;

  // Stack entries, occupancy count and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stk0_r  <= '0;
      stk1_r  <= '0;
      depth_r <= 2'd0;
      ovf_r   <= 1'b0;
    end else if (push) begin
      stk1_r <= stk0_r;
      stk0_r <= push_data;
      if (depth_r == 2'd2) begin
        ovf_r <= 1'b1;
      end else begin
        depth_r <= depth_r + 2'd1;
      end
    end else if (pop) begin
      // stk1 deliberately keeps its value: repeated pops return it again.
      stk0_r <= stk1_r;
      if (depth_r != 2'd0) begin
        depth_r <= depth_r - 2'd1;
      end
    end
  end

  assign top     = stk0_r;
  assign stk_ovf = ovf_r;

endmodule

// File: rtl/fetch_seq.sv
// Instruction fetch and sequencing: PC, IR, Q1..Q4 phase counter and
// branch/skip resolution by flushing the prefetched word to a NOP.
module fetch_seq #(
  parameter int              PC_W      = pic_pkg::PC_W,
  parameter int              IW        = pic_pkg::IW,
  parameter logic [PC_W-1:0] RESET_VEC = 9'h0FF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  output logic [PC_W-1:0] pm_addr,
  input  logic [IW-1:0]   pm_data,
  output logic [IW-1:0]   ir_bus,
  output logic [1:0]      q_phase,
  output logic            cyc_end,
  output logic            instr_valid,
  input  logic            fz,
  input  logic            skip_req,
  input  logic            pcl_wr,
  input  logic [7:0]      pcl_data,
  output logic            stk_ovf
);

  import pic_pkg::*;

  q_phase_t        q_r;
  q_phase_t        q_nxt_s;
  logic [PC_W-1:0] pc_r;
  logic [PC_W-1:0] pc_nxt_s;
  logic [IW-1:0]   ir_r;
  logic [IW-1:0]   ir_nxt_s;
  logic            valid_r;
  logic            valid_nxt_s;
  logic            push_s;
  logic            pop_s;
  logic [PC_W-1:0] stk_top_s;
  logic            boundary_s;
  logic            is_goto_s;
  logic            is_call_s;
  logic            is_retlw_s;
  logic            is_fsz_s;

  assign boundary_s = en && (q_r == Q4);
  assign is_goto_s  = op_match(ir_r, GOTO_MASK, GOTO_MATCH);
  assign is_call_s  = op_match(ir_r, CALL_MASK, CALL_MATCH);
  assign is_retlw_s = op_match(ir_r, RETLW_MASK, RETLW_MATCH);
  assign is_fsz_s   = op_match(ir_r, DECFSZ_MASK, DECFSZ_MATCH) ||
                      op_match(ir_r, INCFSZ_MASK, INCFSZ_MATCH);

  // Q phase advance: one step per enabled clock, wrapping Q4 -> Q1.
  always_comb begin
    q_nxt_s = q_r;
    if (en) begin
      case (q_r)
        Q1:      q_nxt_s = Q2;
        Q2:      q_nxt_s = Q3;
        Q3:      q_nxt_s = Q4;
        Q4:      q_nxt_s = Q1;
        default: q_nxt_s = Q1;
      endcase
    end else begin
      q_nxt_s = q_r;
    end
  end

  // Boundary resolution of the next PC/IR in priority order; a flushed
  // slot loads NOP so a taken branch always costs two instruction cycles.
  always_comb begin
    pc_nxt_s    = pc_r;
    ir_nxt_s    = ir_r;
    valid_nxt_s = valid_r;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    if (boundary_s) begin
      if (is_goto_s) begin
        pc_nxt_s    = ir_r[PC_W-1:0];
        ir_nxt_s    = NOP_INSTR;
        valid_nxt_s = 1'b0;
      end else if (is_call_s) begin
        push_s      = 1'b1;
        pc_nxt_s    = PC_W'(ir_r[7:0]);
        ir_nxt_s    = NOP_INSTR;
        valid_nxt_s = 1'b0;
      end else if (is_retlw_s) begin
        pop_s       = 1'b1;
        pc_nxt_s    = stk_top_s;
        ir_nxt_s    = NOP_INSTR;
        valid_nxt_s = 1'b0;
      end else if (pcl_wr) begin
        pc_nxt_s    = PC_W'(pcl_data);
        ir_nxt_s    = NOP_INSTR;
        valid_nxt_s = 1'b0;
      end else if (skip_req || (is_fsz_s && fz)) begin
        pc_nxt_s    = pc_r + PC_W'(1);
        ir_nxt_s    = NOP_INSTR;
        valid_nxt_s = 1'b0;
      end else begin
        pc_nxt_s    = pc_r + PC_W'(1);
        ir_nxt_s    = pm_data;
        valid_nxt_s = 1'b1;
      end
    end else begin
      pc_nxt_s    = pc_r;
      ir_nxt_s    = ir_r;
      valid_nxt_s = valid_r;
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r     <= Q1;
      pc_r    <= RESET_VEC;
      ir_r    <= NOP_INSTR;
      valid_r <= 1'b0;
    end else begin
      q_r     <= q_nxt_s;
      pc_r    <= pc_nxt_s;
      ir_r    <= ir_nxt_s;
      valid_r <= valid_nxt_s;
    end
  end

  call_stack #(.W(PC_W)) u_call_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (pc_r),
    .top       (stk_top_s),
    .stk_ovf   (stk_ovf)
  );

  assign pm_addr     = pc_r;
  assign ir_bus      = ir_r;
  assign q_phase     = q_r;
  assign cyc_end     = (q_r == Q4);
  assign instr_valid = valid_r;

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: a small ROM program walks through fetch,
// GOTO, CALL/RETLW, DECFSZ skip, external skip, PCL write, stack overflow,
// clock-enable hold and asynchronous reset in the middle of a branch.
module tb_fetch_seq;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [8:0]  pm_addr;
  logic [11:0] pm_data;
  logic [11:0] ir_bus;
  logic [1:0]  q_phase;
  logic        cyc_end;
  logic        instr_valid;
  logic        fz;
  logic        skip_req;
  logic        pcl_wr;
  logic [7:0]  pcl_data;
  logic        stk_ovf;

  logic [11:0] rom [0:511];
  int          vectors;
  int          errors;

  assign pm_data = rom[pm_addr];

  fetch_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .pm_addr     (pm_addr),
    .pm_data     (pm_data),
    .ir_bus      (ir_bus),
    .q_phase     (q_phase),
    .cyc_end     (cyc_end),
    .instr_valid (instr_valid),
    .fz          (fz),
    .skip_req    (skip_req),
    .pcl_wr      (pcl_wr),
    .pcl_data    (pcl_data),
    .stk_ovf     (stk_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full instruction cycle (4 enabled clocks), ending on a negedge.
  task automatic step();
    repeat (4) @(negedge clk);
  endtask

  task automatic chk_state(input string tag, input logic [11:0] ir_e,
                           input logic v_e, input logic [8:0] pc_e);
    chk({tag, ".ir"}, ir_bus, ir_e);
    chk({tag, ".valid"}, {11'd0, instr_valid}, {11'd0, v_e});
    chk({tag, ".pc"}, {3'd0, pm_addr}, {3'd0, pc_e});
  endtask

  initial begin
    vectors  = 0;
    errors   = 0;
    for (int i = 0; i < 512; i++) rom[i] = {4'hC, i[7:0]};
    rom[9'h0FF] = 12'hC25;   // MOVLW
    rom[9'h100] = 12'hA10;   // GOTO 0x010
    rom[9'h010] = 12'hA40;   // GOTO 0x040
    rom[9'h041] = 12'hA20;   // GOTO 0x020
    rom[9'h020] = 12'h9A5;   // CALL 0xA5
    rom[9'h0A5] = 12'h877;   // RETLW
    rom[9'h022] = 12'h2C5;   // DECFSZ
    rom[9'h025] = 12'h2C6;   // DECFSZ
    rom[9'h027] = 12'h930;   // CALL 0x30
    rom[9'h030] = 12'h950;   // CALL 0x50
    rom[9'h050] = 12'h970;   // CALL 0x70
    rom[9'h070] = 12'h800;   // RETLW
    rom[9'h051] = 12'h800;   // RETLW
    rom[9'h031] = 12'h800;   // RETLW
    rom[9'h063] = 12'h9A5;   // CALL 0xA5

    rst_n    = 1'b0;
    en       = 1'b1;
    fz       = 1'b0;
    skip_req = 1'b0;
    pcl_wr   = 1'b0;
    pcl_data = 8'h00;
    repeat (2) @(negedge clk);
    chk_state("reset", 12'h000, 1'b0, 9'h0FF);
    chk("reset.q", {10'd0, q_phase}, 12'd0);
    chk("reset.ovf", {11'd0, stk_ovf}, 12'd0);
    rst_n = 1'b1;

    // First fetch: 9-bit PC moves from RESET_VEC 0x0FF to 0x100.
    step(); chk_state("s1_movlw", 12'hC25, 1'b1, 9'h100);
    step(); chk_state("s2_goto_fetch", 12'hA10, 1'b1, 9'h101);
    step(); chk_state("s3_goto_flush", 12'h000, 1'b0, 9'h010);
    step(); chk_state("s4", 12'hA40, 1'b1, 9'h011);
    step(); chk_state("s5_goto40_flush", 12'h000, 1'b0, 9'h040);
    step(); chk_state("s6_target", 12'hC40, 1'b1, 9'h041);
    step(); step(); chk_state("s8", 12'h000, 1'b0, 9'h020);
    step(); chk_state("s9_call", 12'h9A5, 1'b1, 9'h021);
    step(); chk_state("s10_call_flush", 12'h000, 1'b0, 9'h0A5);
    step(); chk_state("s11_retlw", 12'h877, 1'b1, 9'h0A6);
    step(); chk_state("s12_ret_flush", 12'h000, 1'b0, 9'h021);
    step(); chk_state("s13_resume", 12'hC21, 1'b1, 9'h022);
    step(); chk_state("s14_decfsz", 12'h2C5, 1'b1, 9'h023);
    fz = 1'b1;
    step(); chk_state("s15_skip", 12'h000, 1'b0, 9'h024);
    fz = 1'b0;
    step(); chk_state("s16_after_skip", 12'hC24, 1'b1, 9'h025);
    step(); chk_state("s17_decfsz", 12'h2C6, 1'b1, 9'h026);
    step(); chk_state("s18_noskip", 12'hC26, 1'b1, 9'h027);
    skip_req = 1'b1;
    step(); chk_state("s19_skip_req", 12'h000, 1'b0, 9'h028);
    skip_req = 1'b0;
    pcl_wr = 1'b1; pcl_data = 8'h27;
    step(); chk_state("s20_pcl_wr", 12'h000, 1'b0, 9'h027);
    pcl_wr = 1'b0;
    step(); chk_state("s21_call1", 12'h930, 1'b1, 9'h028);
    step(); step(); step();
    chk_state("s24_call2_flush", 12'h000, 1'b0, 9'h050);
    chk("s24.ovf", {11'd0, stk_ovf}, 12'd0);
    step(); step();
    chk_state("s26_call3_flush", 12'h000, 1'b0, 9'h070);
    chk("s26.ovf", {11'd0, stk_ovf}, 12'd1);
    step(); step(); chk_state("s28_ret1", 12'h000, 1'b0, 9'h051);
    step(); step(); chk_state("s30_ret2", 12'h000, 1'b0, 9'h031);
    step(); step(); chk_state("s32_ret3_stale", 12'h000, 1'b0, 9'h031);
    step(); chk_state("s33", 12'h800, 1'b1, 9'h032);

    // Hold the boundary with en low for five clocks.
    repeat (3) @(negedge clk);
    chk("q4.cyc_end", {11'd0, cyc_end}, 12'd1);
    en = 1'b0;
    repeat (5) @(negedge clk);
    chk("hold.q", {10'd0, q_phase}, 12'd3);
    chk_state("hold", 12'h800, 1'b1, 9'h032);
    en = 1'b1;
    @(negedge clk);
    chk("resume.q", {10'd0, q_phase}, 12'd0);
    chk_state("resume_ret", 12'h000, 1'b0, 9'h031);

    // Escape the return loop via PCL write during the flush slot.
    pcl_wr = 1'b1; pcl_data = 8'h63;
    step(); chk_state("pcl_escape", 12'h000, 1'b0, 9'h063);
    pcl_wr = 1'b0;
    step(); chk_state("call_fetch", 12'h9A5, 1'b1, 9'h064);
    step(); chk_state("call_flush", 12'h000, 1'b0, 9'h0A5);
    @(negedge clk);
    chk("q2.q", {10'd0, q_phase}, 12'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_state("async_rst", 12'h000, 1'b0, 9'h0FF);
    chk("async_rst.q", {10'd0, q_phase}, 12'd0);
    chk("async_rst.cyc_end", {11'd0, cyc_end}, 12'd0);
    chk("async_rst.ovf", {11'd0, stk_ovf}, 12'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(); chk_state("refetch", 12'hC25, 1'b1, 9'h100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
